// File: rtl/datapath_mode_pkg.sv
// Shared types for the datapath mode controller: FSM states, mode codes and
// the mode-to-select routing table.
package datapath_mode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_RESET  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  localparam logic [2:0] MODE_FULL          = 3'b000;
  localparam logic [2:0] MODE_DIRECT        = 3'b001;
  localparam logic [2:0] MODE_FILTER_NARROW = 3'b010;
  localparam logic [2:0] MODE_FILTER_WIDE   = 3'b011;
  localparam logic [2:0] MODE_DEMOD_IQ      = 3'b100;
  localparam logic [2:0] MODE_DEMOD_IQ_ALT  = 3'b101;
  localparam logic [2:0] MODE_DECIMATE      = 3'b110;
  localparam logic [2:0] MODE_CODER_CORDIC  = 3'b111;

  typedef struct packed {
    logic [2:0] sel1;
    logic [1:0] sel9;
    logic [1:0] sel15;
  } sel_t;

  // SEL1 always mirrors the mode code; only SEL9/SEL15 need per-mode routing.
  function automatic sel_t mode_to_sel(input logic [2:0] mode);
    sel_t s;
    s.sel1  = mode;
    s.sel9  = 2'b00;
    s.sel15 = 2'b00;
    case (mode)
      MODE_FILTER_NARROW: s.sel15 = 2'b01;
      MODE_FILTER_WIDE:   s.sel15 = 2'b10;
      MODE_DEMOD_IQ,
      MODE_DEMOD_IQ_ALT: begin
        s.sel9  = 2'b11;
        s.sel15 = 2'b11;
      end
      MODE_DECIMATE: begin
        s.sel9  = 2'b10;
        s.sel15 = 2'b01;
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic mode_reads_fifo(input logic [2:0] mode);
    return (mode == MODE_FULL) || (mode == MODE_CODER_CORDIC);
  endfunction

endpackage

// File: rtl/symbol_read_sched.sv
// Paces inFIFO read pulses: at most one read per SYMBOL_PERIOD cycles while
// running in a FIFO-consuming mode.
module symbol_read_sched
  import datapath_mode_pkg::*;
#(
  parameter int SYMBOL_PERIOD = 32
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       i_run,
  input  logic [2:0] i_mode,
  input  logic       i_fifo_empty,
  input  logic       i_hold,
  output logic       o_read
);

  localparam int GAP_W = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;

  logic [GAP_W-1:0] r_gap;
  logic             w_read;

  assign w_read = i_run && mode_reads_fifo(i_mode) && !i_fifo_empty &&
                  !i_hold && (r_gap == '0);
  assign o_read = w_read;

  // Held at zero outside RUN so the first read can land on the first RUN cycle.
  always_ff @(posedge inClock) begin
    if (!inReset || !i_run) begin
      r_gap <= '0;
    end else if (w_read) begin
      r_gap <= GAP_W'(SYMBOL_PERIOD - 1);
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

endmodule

// File: rtl/datapath_mode_ctrl.sv
// Datapath mode sequencer: drains, resets and settles the datapath around
// every mode switch, then runs the symbol read scheduler.
module datapath_mode_ctrl
  import datapath_mode_pkg::*;
#(
  parameter int RESET_CYCLES  = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int SYMBOL_PERIOD = 32
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic [2:0] inModeReq,
  input  logic       inModeValid,
  output logic       outModeReady,
  input  logic       inDpBusy,
  input  logic       inFifoEmpty,
  output logic       outFifoReadEnable,
  output logic [2:0] outSEL1,
  output logic [1:0] outSEL9,
  output logic [1:0] outSEL15,
  output logic       outDpReset,
  output logic       outActive,
  output logic [2:0] outMode
);

  // state  | meaning
  // IDLE   | no mode applied yet, datapath held in reset
  // DRAIN  | waiting for datapath idle (or timeout) before a switch
  // RESET  | datapath reset asserted, selects already switched
  // SETTLE | reset released, datapath settling
  // RUN    | mode active, FIFO reads scheduled

  localparam int CNT_MAX =
    (DRAIN_TIMEOUT > RESET_CYCLES)
      ? ((DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES)
      : ((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_mode;
  logic [2:0]       w_sel_mode;
  sel_t             r_sel;
  logic             w_ready;
  logic             w_accept;
  logic             w_reset_entry;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_accept = inModeValid && w_ready;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_RESET;
          w_cnt_next   = CNT_W'(RESET_CYCLES - 1);
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_next_state = ST_DRAIN;
          w_cnt_next   = CNT_W'(DRAIN_TIMEOUT - 1);
        end
      end
      ST_DRAIN: begin
        if (!inDpBusy || (r_cnt == '0)) begin
          w_next_state = ST_RESET;
          w_cnt_next   = CNT_W'(RESET_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RESET: begin
        if (r_cnt == '0) begin
          w_next_state = ST_SETTLE;
          w_cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // From IDLE the new mode is latched on the same edge RESET is entered.
  assign w_sel_mode    = (r_state == ST_IDLE) ? inModeReq : r_mode;
  assign w_reset_entry = (w_next_state == ST_RESET) && (r_state != ST_RESET);

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_FULL;
      r_sel   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_mode <= inModeReq;
      end
      if (w_reset_entry) begin
        r_sel <= mode_to_sel(w_sel_mode);
      end
    end
  end

  symbol_read_sched #(
    .SYMBOL_PERIOD(SYMBOL_PERIOD)
  ) u_read_sched (
    .inClock     (inClock),
    .inReset     (inReset),
    .i_run       (r_state == ST_RUN),
    .i_mode      (r_mode),
    .i_fifo_empty(inFifoEmpty),
    .i_hold      (w_accept),
    .o_read      (outFifoReadEnable)
  );

  assign outModeReady = w_ready;
  assign outDpReset   = (r_state != ST_IDLE) && (r_state != ST_RESET);
  assign outActive    = (r_state == ST_RUN);
  assign outMode      = r_mode;
  assign outSEL1      = r_sel.sel1;
  assign outSEL9      = r_sel.sel9;
  assign outSEL15     = r_sel.sel15;

endmodule

// File: doc/datapath_mode_ctrl.md
DATAPATH_MODE_CTRL -- requirements
Module: datapath_mode_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 5: cycles outDpReset is held low per mode switch.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles between datapath reset release and RUN.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 64: maximum cycles spent waiting for the datapath to go idle.
REQ-004 SHALL have parameter SYMBOL_PERIOD, default 32: minimum cycles between inFIFO read pulses.
REQ-005 SHALL have inClock, input, 1: the single clock, rising edge.
REQ-006 SHALL have inReset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have inModeReq, input, 3: requested datapath mode code.
REQ-008 SHALL have inModeValid, input, 1: mode request strobe.
REQ-009 SHALL have outModeReady, output, 1: request may be accepted this cycle.
REQ-010 SHALL have inDpBusy, input, 1: datapath still processing.
REQ-011 SHALL have inFifoEmpty, input, 1: inFIFO empty flag.
REQ-012 SHALL have outFifoReadEnable, output, 1: one-cycle inFIFO read pulse.
REQ-013 SHALL have outSEL1 (3), outSEL9 (2) and outSEL15 (2), all outputs: DEMUX/MUX selects.
REQ-014 SHALL have outDpReset, output, 1: active-low datapath reset.
REQ-015 SHALL have outActive, output, 1: high in RUN.
REQ-016 SHALL have outMode, output, 3: currently applied mode.

Function
REQ-017 SHALL implement states IDLE, DRAIN, RESET, SETTLE and RUN.
REQ-018 SHALL drive outModeReady high only in IDLE and RUN; accept a request when inModeValid and outModeReady are both high; ignore inModeValid in all other states.
REQ-019 SHALL, on accept, latch inModeReq into outMode and go to DRAIN from RUN, or to RESET from IDLE.
REQ-020 SHALL leave DRAIN for RESET when inDpBusy is low, or after DRAIN_TIMEOUT cycles in DRAIN, whichever comes first.
REQ-021 SHALL update outSEL1/9/15 from the mode table on the RESET-entry edge and hold them until the next RESET entry.
REQ-022 SHALL drive outDpReset low for exactly RESET_CYCLES cycles in RESET, then enter SETTLE with outDpReset high.
REQ-023 SHALL go to RUN after SETTLE_CYCLES cycles in SETTLE; outActive SHALL be high exactly in RUN.
REQ-024 SHALL apply this mode table (mode -> SEL1/SEL9/SEL15): 000->000/00/00, 001->001/00/00, 010->010/00/01, 011->011/00/10, 100->100/11/11, 101->101/11/11, 110->110/10/01, 111->111/00/00.
REQ-025 SHALL hold outDpReset low in IDLE.
REQ-026 SHALL, on a request for the current mode in RUN, perform the full DRAIN/RESET/SETTLE sequence (re-arm).
REQ-027 SHALL issue outFifoReadEnable only in RUN, only in modes 000 or 111, and only when inFifoEmpty is low and the symbol gap counter is 0.
REQ-028 SHALL reload the gap counter to SYMBOL_PERIOD-1 on each read pulse and decrement it to 0 otherwise; the counter SHALL be cleared on RUN entry, so the first read may occur in the first RUN cycle.
REQ-029 SHALL NOT issue a read pulse on the cycle a new request is accepted, nor in any state other than RUN.
REQ-030 SHALL suppress the read while inFifoEmpty is high, leaving the counter at 0 so the read fires on the first non-empty cycle.

Reset
REQ-031 SHALL, while inReset is low at a clock edge, set: state IDLE, outMode 000, all SEL outputs 0, outDpReset 0, outActive 0, outFifoReadEnable 0, all counters 0.
REQ-032 SHALL honour reset mid-sequence (DRAIN/RESET/SETTLE/RUN) and abandon any pending mode.
REQ-033 SHALL drive outModeReady high in the first cycle after reset is released.

Structure
REQ-034 SHALL place the state enum, the mode code constants (MODE_FULL=000 … MODE_CODER_CORDIC=111) and the mode-to-select table function in package datapath_mode_pkg.
REQ-035 SHALL implement the read scheduler (gap counter plus read gating) as sub-module symbol_read_sched; the FSM SHALL remain in the top module.

Verification
REQ-036 SHALL check: reset, then request 010 in IDLE -> outDpReset low for 5 cycles, SEL=010/00/01, outActive high 7 cycles after accept.
REQ-037 SHALL check: in RUN mode 011, request 100 with inDpBusy held high -> RESET entered 64 cycles after accept; with busy dropping after 10 cycles -> RESET entered at cycle 10.
REQ-038 SHALL check: mode 111, FIFO non-empty continuously -> read pulses at RUN cycles 0, 32, 64; inFifoEmpty high during cycles 30-40 -> next pulse at cycle 41.
REQ-039 SHALL check: mode 101, FIFO non-empty -> no read pulses; inModeValid in SETTLE -> ignored, outMode unchanged.
REQ-040 SHALL check: inReset low during the second RESET cycle -> next cycle shows IDLE, outMode 000, SEL 0, outModeReady high.
